// File: rtl/uart_key_decoder_pkg.sv
// ----------------------------------------------------------------------------
// ttt_key_pkg
// Shared definitions for the UART key decoder and the game controller.
//   - Byte constants for the control characters and ANSI cursor sequences.
//   - Escape-sequence parser state enum.
//   - One-hot key index enum; bit positions of the stretched key register,
//     shared with the game controller so both sides agree on key ordering.
// Optional WASD letters are defined here too; they are only decoded when
// UART_KEY_WASD_EN is defined in the decoder build.
// ----------------------------------------------------------------------------
package ttt_key_pkg;

    // Control bytes
    localparam logic [7:0] KEY_ESC      = 8'h1B;
    localparam logic [7:0] KEY_LBRACKET = 8'h5B;
    localparam logic [7:0] KEY_CR       = 8'h0D;
    localparam logic [7:0] KEY_LF       = 8'h0A;
    localparam logic [7:0] KEY_SPACE    = 8'h20;

    // Final byte of an ESC [ x cursor sequence
    localparam logic [7:0] CSI_UP       = 8'h41;
    localparam logic [7:0] CSI_DOWN     = 8'h42;
    localparam logic [7:0] CSI_RIGHT    = 8'h43;
    localparam logic [7:0] CSI_LEFT     = 8'h44;

    // WASD letters, both cases
    localparam logic [7:0] KEY_W_LOWER  = 8'h77;
    localparam logic [7:0] KEY_W_UPPER  = 8'h57;
    localparam logic [7:0] KEY_S_LOWER  = 8'h73;
    localparam logic [7:0] KEY_S_UPPER  = 8'h53;
    localparam logic [7:0] KEY_A_LOWER  = 8'h61;
    localparam logic [7:0] KEY_A_UPPER  = 8'h41;
    localparam logic [7:0] KEY_D_LOWER  = 8'h64;
    localparam logic [7:0] KEY_D_UPPER  = 8'h44;

    // Escape-sequence parser states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ESC  = 2'd1,
        ST_CSI  = 2'd2
    } parse_state_t;

    // Bit index of each key in the one-hot key register
    typedef enum logic [2:0] {
        KEY_IDX_UP    = 3'd0,
        KEY_IDX_DOWN  = 3'd1,
        KEY_IDX_LEFT  = 3'd2,
        KEY_IDX_RIGHT = 3'd3,
        KEY_IDX_ENTER = 3'd4,
        KEY_IDX_SPACE = 3'd5
    } key_idx_t;

    localparam int NUM_KEYS = 6;

endpackage

// File: rtl/uart_key_decoder_if.sv
// ----------------------------------------------------------------------------
// uart_key_decoder_if
// Groups the received-byte stream and the key event outputs of the decoder.
//   rx_data  [7:0]  received byte, valid when rx_valid=1
//   rx_valid        one-cycle strobe per received byte
//   up/down/left/right/enter/space
//                   one-hot key events, each held for the stretch length
//   drop            one-cycle strobe when a decoded key was discarded
// Modports:
//   master  byte source / key consumer (UART side and game controller)
//   slave   the decoder itself
// ----------------------------------------------------------------------------
interface uart_key_decoder_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic       enter;
    logic       space;
    logic       drop;

    modport master (
        output rx_data, rx_valid,
        input  up, down, left, right, enter, space, drop
    );

    modport slave (
        input  rx_data, rx_valid,
        output up, down, left, right, enter, space, drop
    );

endinterface

// File: rtl/uart_key_decoder_key_pulse_stretch.sv
// ----------------------------------------------------------------------------
// key_pulse_stretch
// Holds a decoded key as a one-hot register for exactly PULSE_CYCLES clocks
// so a slower clock domain sees it once. A key arriving while a stretch is
// still running (counter nonzero, including the final held cycle) is
// discarded and reported with a one-cycle drop strobe.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   key_valid    a key was decoded this cycle
//   key_idx      which key (index into key_onehot)
//   key_onehot   stretched one-hot key register
//   drop         one-cycle strobe: key_valid seen while busy
// ----------------------------------------------------------------------------
module key_pulse_stretch
    import ttt_key_pkg::*;
#(
    parameter int PULSE_CYCLES = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_valid,
    input  key_idx_t            key_idx,
    output logic [NUM_KEYS-1:0] key_onehot,
    output logic                drop
);

    localparam int CNT_W = $clog2(PULSE_CYCLES + 1);

    logic [CNT_W-1:0] hold_cnt;

    // The counter loads PULSE_CYCLES with the key and the key is cleared on
    // the edge where the counter leaves 1, giving exactly PULSE_CYCLES
    // cycles high. A new key is accepted only once the counter reads zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_onehot <= '0;
            hold_cnt   <= '0;
            drop       <= 1'b0;
        end else begin
            drop <= key_valid && (hold_cnt != '0);
            if (hold_cnt == '0) begin
                if (key_valid) begin
                    key_onehot <= NUM_KEYS'(1) << key_idx;
                    hold_cnt   <= CNT_W'(PULSE_CYCLES);
                end
            end else begin
                hold_cnt <= hold_cnt - CNT_W'(1);
                if (hold_cnt == CNT_W'(1)) begin
                    key_onehot <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/uart_key_decoder.sv
// ----------------------------------------------------------------------------
// uart_key_decoder
// Turns the UART byte stream into stretched one-hot key events:
//   ESC [ A/B/C/D  -> up/down/right/left
//   CR or LF       -> enter
//   space          -> space
// An escape sequence is abandoned when no byte arrives for ESC_TIMEOUT
// cycles. Decoded keys pass through key_pulse_stretch, which holds each key
// for PULSE_CYCLES cycles and drops keys that arrive mid-stretch.
// Parameters:
//   PULSE_CYCLES  cycles each key output stays high
//   ESC_TIMEOUT   idle cycles tolerated between escape-sequence bytes
// Ports:
//   clk     UART-domain clock
//   reset   asynchronous active-high reset
//   bus     uart_key_decoder_if.slave (rx_data/rx_valid in, keys/drop out)
// Build option:
//   UART_KEY_WASD_EN  also map w/s/a/d (either case) to up/down/left/right
//                     when not inside an escape sequence.
// ----------------------------------------------------------------------------
module uart_key_decoder
    import ttt_key_pkg::*;
#(
    parameter int PULSE_CYCLES = 8,
    parameter int ESC_TIMEOUT  = 100000
) (
    input  logic                clk,
    input  logic                reset,
    uart_key_decoder_if.slave   bus
);

    localparam int TO_W = (ESC_TIMEOUT > 1) ? $clog2(ESC_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ESC_TIMEOUT - 1);

    parse_state_t         state;
    parse_state_t         state_next;
    logic [TO_W-1:0]      timeout_cnt;
    logic                 key_valid;
    key_idx_t             key_idx;
    logic [NUM_KEYS-1:0]  key_onehot;
    logic                 drop;

    // Parser state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Inter-byte timeout: any received byte restarts it and it is held at
    // zero in IDLE. It saturates at TO_LAST so a long silence cannot wrap
    // it back into the valid window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_cnt <= '0;
        end else if (bus.rx_valid || (state == ST_IDLE)) begin
            timeout_cnt <= '0;
        end else if (timeout_cnt != TO_LAST) begin
            timeout_cnt <= timeout_cnt + TO_W'(1);
        end
    end

    // Next-state and key decode. A byte on the same cycle the timeout
    // expires is still parsed in the current state; the timeout only fires
    // on a cycle without rx_valid.
    always_comb begin
        state_next = state;
        key_valid  = 1'b0;
        key_idx    = KEY_IDX_UP;
        if (bus.rx_valid) begin
            case (state)
                ST_IDLE: begin
                    case (bus.rx_data)
                        KEY_ESC: state_next = ST_ESC;
                        KEY_CR, KEY_LF: begin
                            key_valid = 1'b1;
                            key_idx   = KEY_IDX_ENTER;
                        end
                        KEY_SPACE: begin
                            key_valid = 1'b1;
                            key_idx   = KEY_IDX_SPACE;
                        end
`ifdef UART_KEY_WASD_EN
                        KEY_W_LOWER, KEY_W_UPPER: begin
                            key_valid = 1'b1;
                            key_idx   = KEY_IDX_UP;
                        end
                        KEY_S_LOWER, KEY_S_UPPER: begin
                            key_valid = 1'b1;
                            key_idx   = KEY_IDX_DOWN;
                        end
                        KEY_A_LOWER, KEY_A_UPPER: begin
                            key_valid = 1'b1;
                            key_idx   = KEY_IDX_LEFT;
                        end
                        KEY_D_LOWER, KEY_D_UPPER: begin
                            key_valid = 1'b1;
                            key_idx   = KEY_IDX_RIGHT;
                        end
`endif
                        default: state_next = ST_IDLE;
                    endcase
                end
                ST_ESC: begin
                    if (bus.rx_data == KEY_LBRACKET) begin
                        state_next = ST_CSI;
                    end else if (bus.rx_data == KEY_ESC) begin
                        state_next = ST_ESC;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
                ST_CSI: begin
                    state_next = ST_IDLE;
                    case (bus.rx_data)
                        CSI_UP: begin
                            key_valid = 1'b1;
                            key_idx   = KEY_IDX_UP;
                        end
                        CSI_DOWN: begin
                            key_valid = 1'b1;
                            key_idx   = KEY_IDX_DOWN;
                        end
                        CSI_RIGHT: begin
                            key_valid = 1'b1;
                            key_idx   = KEY_IDX_RIGHT;
                        end
                        CSI_LEFT: begin
                            key_valid = 1'b1;
                            key_idx   = KEY_IDX_LEFT;
                        end
                        KEY_ESC: state_next = ST_ESC;
                        default: state_next = ST_IDLE;
                    endcase
                end
                default: state_next = ST_IDLE;
            endcase
        end else if ((state != ST_IDLE) && (timeout_cnt == TO_LAST)) begin
            state_next = ST_IDLE;
        end
    end

    key_pulse_stretch #(
        .PULSE_CYCLES (PULSE_CYCLES)
    ) u_stretch (
        .clk        (clk),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_idx    (key_idx),
        .key_onehot (key_onehot),
        .drop       (drop)
    );

    assign bus.up    = key_onehot[KEY_IDX_UP];
    assign bus.down  = key_onehot[KEY_IDX_DOWN];
    assign bus.left  = key_onehot[KEY_IDX_LEFT];
    assign bus.right = key_onehot[KEY_IDX_RIGHT];
    assign bus.enter = key_onehot[KEY_IDX_ENTER];
    assign bus.space = key_onehot[KEY_IDX_SPACE];
    assign bus.drop  = drop;

endmodule
